// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg -- shared types and constants for the clock-divider
// ratio controller.
//   state_e      : controller FSM state encoding
//   RATIO_W_DEF  : default divide-ratio width
//   SETTLE_W     : width of the settle counter (covers SETTLE_CYC up to 15)
package clk_div_ctrl_pkg;

    localparam int RATIO_W_DEF = 5;
    localparam int SETTLE_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_LOAD,
        ST_RESUME,
        ST_ACK
    } state_e;

endpackage

// File: rtl/clk_div_ctrl_rr_arb.sv
// clk_div_ctrl_rr_arb -- two-way round-robin selector.
//   clk_i      : block clock
//   rst_i      : asynchronous active-high reset (priority back to requester 0)
//   req_i      : pending requests, one bit per requester
//   advance_i  : a request has been completed; move priority away from it
//   served_i   : one-hot requester that was completed when advance_i is high
//   select_o   : one-hot winner among req_i (zero when nothing requested)
module clk_div_ctrl_rr_arb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic [1:0] served_i,
    output logic [1:0] select_o
);

    // 1 = requester 1 wins a tie, 0 = requester 0 wins a tie
    logic prio_q;

    always_comb begin
        select_o = req_i;
        if (&req_i) begin
            select_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (advance_i) begin
            // Whoever was just served loses the next tie.
            prio_q <= (served_i == 2'b01);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl -- sequences divide-ratio changes for a clock divider.
// A requester asks for a new ratio; the divider is gated for SETTLE_CYC
// cycles, the ratio is loaded, the divider is re-enabled for SETTLE_CYC
// cycles, then the requester receives a one-cycle grant. A request for the
// ratio already in use is granted without gating.
//   i_clk        : block clock, rising edge
//   i_rst        : asynchronous active-high reset
//   i_req        : level requests, held until grant
//   i_ratio0/1   : ratio requested by requester 0 / 1
//   o_gnt        : one-hot, one-cycle completion pulse
//   o_div_ratio  : ratio driven to the divider
//   o_clk_en     : divider enable
//   o_busy       : high whenever a sequence is in progress
//   o_switch_cnt : (only with CLK_DIV_CTRL_STATUS_EN) saturating count of
//                  completed ratio loads
// Optional feature macro: CLK_DIV_CTRL_STATUS_EN
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int RATIO_W    = RATIO_W_DEF,
    parameter int SETTLE_CYC = 4,
    parameter int RST_RATIO  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_req,
    input  logic [RATIO_W-1:0] i_ratio0,
    input  logic [RATIO_W-1:0] i_ratio1,
    output logic [1:0]         o_gnt,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_clk_en,
    output logic               o_busy
`ifdef CLK_DIV_CTRL_STATUS_EN
    ,
    output logic [7:0]         o_switch_cnt
`endif
);

    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [RATIO_W-1:0]   RST_VAL     = RATIO_W'(RST_RATIO);

    state_e               state_q;
    logic [SETTLE_W-1:0]  cnt_q;
    logic [RATIO_W-1:0]   pend_q;
    logic [RATIO_W-1:0]   ratio_q;
    logic [1:0]           sel_q;
    logic [1:0]           gnt_q;
    logic                 en_q;
    logic                 busy_q;

    logic [1:0]           arb_sel;
    logic [RATIO_W-1:0]   pick_ratio;

    clk_div_ctrl_rr_arb u_arb (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .req_i     (i_req),
        .advance_i (state_q == ST_ACK),
        .served_i  (sel_q),
        .select_o  (arb_sel)
    );

    assign pick_ratio = arb_sel[1] ? i_ratio1 : i_ratio0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ratio_q <= RST_VAL;
            sel_q   <= '0;
            gnt_q   <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|i_req) begin
                        sel_q  <= arb_sel;
                        pend_q <= pick_ratio;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (pick_ratio == ratio_q) begin
                            // Nothing to change: skip gating entirely.
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_GATE;
                            en_q    <= 1'b0;
                        end
                    end
                end
                ST_GATE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        cnt_q <= cnt_q + SETTLE_W'(1);
                    end
                end
                ST_LOAD: begin
                    ratio_q <= pend_q;
                    en_q    <= 1'b1;
                    state_q <= ST_RESUME;
                end
                ST_RESUME: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + SETTLE_W'(1);
                    end
                end
                ST_ACK: begin
                    // Grant appears the cycle the FSM is back in IDLE.
                    gnt_q   <= sel_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    en_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_gnt       = gnt_q;
    assign o_div_ratio = ratio_q;
    assign o_clk_en    = en_q;
    assign o_busy      = busy_q;

`ifdef CLK_DIV_CTRL_STATUS_EN
    // Counts only sequences that actually reloaded the divider.
    logic       via_load_q;
    logic [7:0] sw_cnt_q;
    logic [7:0] sw_cnt_d;

    always_comb begin
        sw_cnt_d = sw_cnt_q;
        if (state_q == ST_ACK && via_load_q && sw_cnt_q != 8'hFF) begin
            sw_cnt_d = sw_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            via_load_q <= 1'b0;
            sw_cnt_q   <= '0;
        end else begin
            sw_cnt_q <= sw_cnt_d;
            if (state_q == ST_LOAD) begin
                via_load_q <= 1'b1;
            end else if (state_q == ST_IDLE) begin
                via_load_q <= 1'b0;
            end
        end
    end

    assign o_switch_cnt = sw_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    localparam int RW  = 5;
    localparam int S   = 4;
    localparam int RR  = 8;
    localparam int LAT = 2 * S + 3;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [1:0]    i_req;
    logic [RW-1:0] i_ratio0;
    logic [RW-1:0] i_ratio1;
    logic [1:0]    o_gnt;
    logic [RW-1:0] o_div_ratio;
    logic          o_clk_en;
    logic          o_busy;
`ifdef CLK_DIV_CTRL_STATUS_EN
    logic [7:0]    o_switch_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    clk_div_ctrl #(.RATIO_W(RW), .SETTLE_CYC(S), .RST_RATIO(RR)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_ratio0    (i_ratio0),
        .i_ratio1    (i_ratio1),
        .o_gnt       (o_gnt),
        .o_div_ratio (o_div_ratio),
        .o_clk_en    (o_clk_en),
        .o_busy      (o_busy)
`ifdef CLK_DIV_CTRL_STATUS_EN
        ,
        .o_switch_cnt(o_switch_cnt)
`endif
    );

    // Transaction-level model: a request accepted at edge 0 owns the block
    // for L edges; outputs are a function of the edge offset k.
    bit         m_act, m_dup, m_rr;
    int         m_k, m_L, m_cur, m_pend, m_switch;
    logic [1:0] m_win;
    logic [1:0] e_gnt;
    bit         e_en, e_busy;
    int         e_ratio;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_cur = RR; m_rr = 0; m_switch = 0;
        e_gnt = 0; e_en = 1; e_busy = 0; e_ratio = RR;
    endtask

    task automatic model_edge();
        if (m_act) begin
            m_k++;
        end else if (i_req != 2'b00) begin
            if (i_req == 2'b11) m_win = m_rr ? 2'b10 : 2'b01;
            else                m_win = i_req;
            m_pend = m_win[1] ? int'(i_ratio1) : int'(i_ratio0);
            m_dup  = (m_pend == m_cur);
            m_L    = m_dup ? 2 : LAT;
            m_k    = 0;
            m_act  = 1;
        end
        e_gnt = 0; e_busy = 0; e_en = 1;
        if (m_act) begin
            e_busy = (m_k <= m_L - 2);
            e_en   = m_dup || (m_k > S);
            if (!m_dup && m_k == S + 1) m_cur = m_pend;
            if (m_k == m_L - 1) begin
                e_gnt = m_win;
                m_act = 0;
                m_rr  = (m_win == 2'b01);
                if (!m_dup && m_switch < 255) m_switch++;
            end
        end
        e_ratio = m_cur;
    endtask

    // One clock: advance model on the edge, compare 1 time unit later.
    task automatic step();
        @(posedge i_clk);
        if (i_rst) model_reset();
        else       model_edge();
        #1;
        chk("gnt", o_gnt, e_gnt);
        chk("div_ratio", o_div_ratio, e_ratio);
        chk("clk_en", o_clk_en, e_en);
        chk("busy", o_busy, e_busy);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk("switch_cnt", o_switch_cnt, m_switch);
`endif
    endtask

    task automatic run_to_gnt(output int n, output int low);
        bit seen;
        n = 0; low = 0; seen = 0;
        while (!seen && n < 60) begin
            step();
            n++;
            if (!o_clk_en) low++;
            if (o_gnt != 2'b00) seen = 1;
        end
        if (!seen) chk("gnt_timeout", 0, 1);
    endtask

    task automatic pulse_rst(input string nm);
        i_rst = 1'b1;
        #1;
        chk({nm, "_ratio"}, o_div_ratio, RR);
        chk({nm, "_en"}, o_clk_en, 1);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_gnt"}, o_gnt, 0);
`ifdef CLK_DIV_CTRL_STATUS_EN
        chk({nm, "_swcnt"}, o_switch_cnt, 0);
`endif
        model_reset();
        #2;
        i_rst = 1'b0;
    endtask

    initial begin
        int n, low, g;
        logic [1:0] exp_g [3];
        int exp_r [3];
        i_rst = 1'b1; i_req = 2'b00; i_ratio0 = '0; i_ratio1 = '0;
        model_reset();
        step(); step();
        chk("reset_ratio", o_div_ratio, 8);
        chk("reset_en", o_clk_en, 1);
        chk("reset_busy", o_busy, 0);
        chk("reset_gnt", o_gnt, 0);
        i_rst = 1'b0;

        // Duplicate ratio straight after reset.
        i_ratio0 = 5'd8; i_req = 2'b01;
        run_to_gnt(n, low);
        i_req = 2'b00;
        chk("dup_latency", n, 2);
        chk("dup_gnt", o_gnt, 2'b01);
        chk("dup_en_low", low, 0);
        step(); step();

        // Basic ratio change.
        pulse_rst("rst1");
        i_ratio0 = 5'd4; i_req = 2'b01;
        run_to_gnt(n, low);
        i_req = 2'b00;
        chk("chg_latency", n, 11);
        chk("chg_en_low", low, 5);
        chk("chg_ratio", o_div_ratio, 4);
        chk("chg_gnt", o_gnt, 2'b01);
        step();

        // Bypass ratios; request dropped after acceptance still completes.
        for (int r = 0; r < 2; r++) begin
            i_ratio1 = RW'(r); i_req = 2'b10;
            step();
            i_req = 2'b00;
            run_to_gnt(n, low);
            chk("byp_latency", n + 1, 11);
            chk("byp_ratio", o_div_ratio, r);
            chk("byp_gnt", o_gnt, 2'b10);
            step();
        end

        // Round-robin under held simultaneous requests.
        pulse_rst("rst2");
        i_ratio0 = 5'd6; i_ratio1 = 5'd10; i_req = 2'b11;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_r[0] = 6;     exp_r[1] = 10;    exp_r[2] = 6;
        for (int t = 0; t < 3; t++) begin
            run_to_gnt(n, low);
            chk("rr_gnt", o_gnt, exp_g[t]);
            chk("rr_ratio", o_div_ratio, exp_r[t]);
            chk("rr_latency", n, 11);
        end
        i_req = 2'b00;
        step();

        // Reset in the middle of GATE: no grant, reset values restored.
        i_ratio0 = 5'd5; i_req = 2'b01;
        step(); step();
        chk("gate_en", o_clk_en, 0);
        pulse_rst("rst_gate");
        i_req = 2'b00;
        g = 0;
        repeat (15) begin
            step();
            if (o_gnt != 2'b00) g++;
        end
        chk("gate_no_gnt", g, 0);

        // Ratio change during RESUME is ignored.
        i_ratio1 = 5'd3; i_req = 2'b10;
        repeat (7) step();
        chk("resume_en", o_clk_en, 1);
        chk("resume_busy", o_busy, 1);
        i_ratio1 = 5'd12;
        run_to_gnt(n, low);
        i_req = 2'b00;
        chk("resume_ratio", o_div_ratio, 3);
        repeat (3) step();
        chk("resume_ratio_hold", o_div_ratio, 3);

`ifdef CLK_DIV_CTRL_STATUS_EN
        pulse_rst("rst_sw");
        i_ratio0 = 5'd8; i_req = 2'b01;
        run_to_gnt(n, low);
        i_req = 2'b00;
        step();
        chk("sw_dup_noinc", o_switch_cnt, 0);
        for (int t = 0; t < 300; t++) begin
            i_ratio0 = (t % 2 == 0) ? 5'd3 : 5'd9;
            i_req = 2'b01;
            run_to_gnt(n, low);
            i_req = 2'b00;
            step();
            if (t == 9) chk("sw_ten", o_switch_cnt, 10);
        end
        chk("sw_sat", o_switch_cnt, 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL expose parameter RATIO_W, default 5, as the divide-ratio width.
REQ-002 The block SHALL expose parameter SETTLE_CYC, default 4, as the cycles the divider is held gated before and after a ratio load (legal 1..15).
REQ-003 The block SHALL expose parameter RST_RATIO, default 8, as the ratio driven out of reset.
REQ-004 i_clk  in  1  single block clock, rising-edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_req  in  2  per-requester ratio-change request, level, held until grant.
REQ-007 i_ratio0 / i_ratio1  in  RATIO_W each  requested ratio from requester 0 / 1.
REQ-008 o_gnt  out  2  one-hot, one-cycle completion pulse to the served requester.
REQ-009 o_div_ratio  out  RATIO_W  ratio driven to the clock divider.
REQ-010 o_clk_en  out  1  enable driven to the clock divider.
REQ-011 o_busy  out  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, GATE, LOAD, RESUME, ACK.
REQ-013 IDLE: when any i_req bit is high, the block SHALL select one requester, latch its ratio into a pending register, and move to GATE next cycle.
REQ-014 Selection SHALL be round-robin: on simultaneous requests, the requester not served last wins; the pointer after reset favours requester 0.
REQ-015 If the latched ratio equals o_div_ratio, the block SHALL go IDLE -> ACK directly, leaving o_clk_en high.
REQ-016 GATE: o_clk_en SHALL be 0; the block SHALL count SETTLE_CYC cycles, then enter LOAD.
REQ-017 LOAD: o_div_ratio SHALL take the pending ratio at the end of this single cycle; o_clk_en stays 0.
REQ-018 RESUME: o_clk_en SHALL be 1; the block SHALL count SETTLE_CYC cycles, then enter ACK.
REQ-019 ACK: the block SHALL pulse o_gnt for the served requester for exactly one cycle, update the round-robin pointer, and return to IDLE.
REQ-020 Non-duplicate request-to-grant latency SHALL be exactly 2*SETTLE_CYC+3 cycles; duplicate-ratio latency SHALL be 2 cycles.
REQ-021 Ratios 0 and 1 (divider bypass) SHALL be loaded through the same sequence as any other ratio.
REQ-022 i_req and i_ratio changes outside IDLE SHALL be ignored; a request dropped before grant SHALL NOT abort an in-progress sequence.
REQ-023 A request still high on the cycle after its grant SHALL be treated as a new request.

Reset
REQ-024 On i_rst, the block SHALL immediately force state IDLE, o_div_ratio=RST_RATIO, o_clk_en=1, o_gnt=0, o_busy=0, counter=0, RR pointer=requester 0.
REQ-025 Reset asserted mid-sequence SHALL discard the pending ratio without a grant.

Configuration
REQ-026 With CLK_DIV_CTRL_STATUS_EN defined, the block SHALL add output o_switch_cnt (8 bits, reset 0), incremented on each ACK reached via LOAD and saturating at 255.
REQ-027 Without CLK_DIV_CTRL_STATUS_EN, o_switch_cnt and its logic SHALL NOT exist.

Structure
REQ-028 Package clk_div_ctrl_pkg SHALL hold the state enum, RATIO_W default, and the settle-counter width constant.
REQ-029 Round-robin selection SHALL be a sub-module clk_div_ctrl_rr_arb (inputs req[1:0], advance; output one-hot select).

Verification
REQ-030 Reset release, i_req=01, i_ratio0=4, SETTLE_CYC=4 -> o_clk_en low for 5 cycles, o_div_ratio=4, o_gnt=01 exactly 11 cycles after request sampled.
REQ-031 i_req=11 held, i_ratio0=6, i_ratio1=10 -> grants alternate 01, 10, 01; o_div_ratio alternates 6, 10, 6.
REQ-032 i_req=01 with i_ratio0=8 right after reset -> o_gnt=01 two cycles later, o_clk_en never drops.
REQ-033 i_rst pulsed during GATE -> o_clk_en=1, o_div_ratio=8, no o_gnt pulse, state IDLE.
REQ-034 i_ratio1 changed from 3 to 12 during RESUME -> o_div_ratio stays 3 until next request.
REQ-035 With CLK_DIV_CTRL_STATUS_EN, 300 alternating ratio changes -> o_switch_cnt=255; duplicate-ratio grants do not increment it.
